// File: rtl/fpxx_addsub_pipe.sv
// fpxx_addsub_pipe: 5-stage pipelined floating-point add/subtract with flush-to-zero and status flags.
// Define FPXX_ADDSUB_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpxx_addsub_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                  osc_clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_sub,
    input  logic [EXP_W+MANT_W:0] op_a,
    input  logic [EXP_W+MANT_W:0] op_b,
    output logic                  out_valid,
    output logic [EXP_W+MANT_W:0] result,
    output logic                  out_ovf,
    output logic                  out_unf,
    output logic                  out_nan
);
    localparam int W = EXP_W + MANT_W + 1;
    localparam int M = MANT_W + 4;
    localparam int LZ_W = $clog2(MANT_W + 5);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W-1:0] CAP = EXP_W'(MANT_W + 3);
`ifdef FPXX_ADDSUB_ROUND_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic             v;
        logic             s;
        logic [EXP_W-1:0] e;
        logic             sp;
        logic             nan;
        logic [W-1:0]     spr;
    } ctl_t;

    logic v0_q, sub0_q;
    logic [W-1:0] a0_q, b0_q;
    ctl_t c1_d, c1_q, c2_q, c3_q, c4_q;
    logic [MANT_W:0] mx1_d, my1_d, mx1_q, my1_q, mx2_q;
    logic [EXP_W-1:0] diff1_d, diff1_q;
    logic esub1_d, esub1_q, esub2_q;
    logic [M-1:0] my2_d, my2_q;
    logic [M:0] sum3_d, sum3_q, sum4_q;
    logic [LZ_W-1:0] lz4_d, lz4_q;
    logic [W-1:0] res_d;
    logic ovf_d, unf_d, nan_d;

    logic sa, sb, za, zb, ia, ib, na, nb, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [MANT_W-1:0] fa, fb;
    logic [MANT_W:0] ma, mb;
    always_comb begin
        {sa, ea, fa} = a0_q;
        {sb, eb, fb} = {b0_q[W-1] ^ sub0_q, b0_q[W-2:0]};
        za = ea == '0;
        zb = eb == '0;
        ia = ea == EMAX && fa == '0;
        ib = eb == EMAX && fb == '0;
        na = ea == EMAX && fa != '0;
        nb = eb == EMAX && fb != '0;
        ma = za ? '0 : {1'b1, fa};
        mb = zb ? '0 : {1'b1, fb};
        swap = {eb, mb} > {ea, ma};
        mx1_d = swap ? mb : ma;
        my1_d = swap ? ma : mb;
        diff1_d = swap ? eb - ea : ea - eb;
        esub1_d = sa ^ sb;
        c1_d.v = v0_q;
        c1_d.s = swap ? sb : sa;
        c1_d.e = swap ? eb : ea;
        c1_d.nan = na | nb | (ia & ib & (sa ^ sb));
        c1_d.sp = c1_d.nan | ia | ib | (za & zb);
        c1_d.spr = c1_d.nan ? {1'b0, EMAX, 1'b1, {(MANT_W-1){1'b0}}}
                 : (ia | ib) ? {ia ? sa : sb, EMAX, {MANT_W{1'b0}}}
                 : {sa & sb, {(W-1){1'b0}}};
    end

    // bits shifted past the sticky position are OR-ed back into it
    logic [EXP_W-1:0] sh;
    logic [M-1:0] ext2;
    always_comb begin
        sh = diff1_q > CAP ? CAP : diff1_q;
        ext2 = {my1_q, 3'b000};
        my2_d = (ext2 >> sh) | {{(M-1){1'b0}}, |(ext2 & ~({M{1'b1}} << sh))};
    end

    assign sum3_d = esub2_q ? {1'b0, mx2_q, 3'b000} - {1'b0, my2_q}
                            : {1'b0, mx2_q, 3'b000} + {1'b0, my2_q};

    always_comb begin
        lz4_d = LZ_W'(M);
        for (int i = 0; i < M; i++)
            if (sum3_q[i]) lz4_d = LZ_W'(M - 1 - i);
    end

    logic carry, zero, inc, unf, ovf;
    logic [M-1:0] nm;
    logic [EXP_W+1:0] en, er;
    logic [MANT_W+1:0] mr;
    logic [MANT_W-1:0] fr;
    always_comb begin
        carry = sum4_q[M];
        zero = sum4_q == '0;
        nm = carry ? {sum4_q[M:2], |sum4_q[1:0]} : sum4_q[M-1:0] << lz4_q;
        en = carry ? {2'b00, c4_q.e} + (EXP_W+2)'(1) : {2'b00, c4_q.e} - (EXP_W+2)'(lz4_q);
        inc = RNE & nm[2] & (nm[3] | nm[1] | nm[0]);
        mr = {1'b0, nm[M-1:3]} + (MANT_W+2)'(inc);
        er = mr[MANT_W+1] ? en + (EXP_W+2)'(1) : en;
        fr = mr[MANT_W+1] ? mr[MANT_W:1] : mr[MANT_W-1:0];
        unf = !zero && (en[EXP_W+1] || en == '0);
        ovf = !zero && !unf && er >= {2'b00, EMAX};
        nan_d = c4_q.sp & c4_q.nan;
        unf_d = !c4_q.sp & unf;
        ovf_d = !c4_q.sp & ovf;
        res_d = c4_q.sp ? c4_q.spr
              : zero ? '0
              : unf ? {c4_q.s, {(W-1){1'b0}}}
              : ovf ? {c4_q.s, EMAX, {MANT_W{1'b0}}}
              : {c4_q.s, er[EXP_W-1:0], fr};
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            v0_q <= 1'b0;
            sub0_q <= 1'b0;
            a0_q <= '0;
            b0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
            c3_q <= '0;
            c4_q <= '0;
            mx1_q <= '0;
            my1_q <= '0;
            diff1_q <= '0;
            esub1_q <= 1'b0;
            mx2_q <= '0;
            my2_q <= '0;
            esub2_q <= 1'b0;
            sum3_q <= '0;
            sum4_q <= '0;
            lz4_q <= '0;
            out_valid <= 1'b0;
            result <= '0;
            out_ovf <= 1'b0;
            out_unf <= 1'b0;
            out_nan <= 1'b0;
        end else begin
            v0_q <= in_valid;
            sub0_q <= in_sub;
            a0_q <= op_a;
            b0_q <= op_b;
            c1_q <= c1_d;
            mx1_q <= mx1_d;
            my1_q <= my1_d;
            diff1_q <= diff1_d;
            esub1_q <= esub1_d;
            c2_q <= c1_q;
            mx2_q <= mx1_q;
            my2_q <= my2_d;
            esub2_q <= esub1_q;
            c3_q <= c2_q;
            sum3_q <= sum3_d;
            c4_q <= c3_q;
            sum4_q <= sum3_q;
            lz4_q <= lz4_d;
            out_valid <= c4_q.v;
            if (c4_q.v) begin
                result <= res_d;
                out_ovf <= ovf_d;
                out_unf <= unf_d;
                out_nan <= nan_d;
            end
        end
    end
endmodule
